// File: rtl/scalar_mul_operand_loader.sv
// Host-side loader for the scalar-multiplication RAM port a: packs Word-wide host
// beats into one Data-wide operand for writes and streams a stored operand back as beats.
module scalar_mul_operand_loader #(
    parameter int unsigned Data = 256,
    parameter int unsigned Addr = 5,
    parameter int unsigned Word = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd,
    input  logic [Addr:0]     cmd_addr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [Word-1:0]   wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [Word-1:0]   rd_data,
    output logic              busy,
    output logic              done,
    output logic              a_w,
    output logic [Addr:0]     a_adbus,
    output logic [Data-1:0]   a_data_in,
    input  logic [Data-1:0]   a_data_out
);

    localparam int unsigned N     = Data / Word;
    localparam int unsigned BeatW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_STREAM
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [Addr:0]      addr_q;
    logic [Data-1:0]    operand_q;
    logic [BeatW-1:0]   beat_q;
    logic [BeatW-1:0]   beat_inc_c;
    logic               last_beat_c;
    logic               wr_hs_c;
    logic               rd_hs_c;

    assign beat_inc_c  = beat_q + BeatW'(1);
    assign last_beat_c = (beat_q == BeatW'(N - 1));
    assign wr_hs_c     = wr_valid && wr_ready;
    assign rd_hs_c     = rd_valid && rd_ready;

    // The RAM sees the latched address and the packed operand directly from registers.
    assign a_adbus   = addr_q;
    assign a_data_in = operand_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (cmd_valid && cmd_ready) state_d = cmd_rd ? S_READ_REQ : S_LOAD;
            S_LOAD:      if (wr_hs_c && last_beat_c) state_d = S_WRITE;
            S_WRITE:     state_d = S_IDLE;
            S_READ_REQ:  state_d = S_READ_WAIT;
            S_READ_WAIT: state_d = S_STREAM;
            S_STREAM:    if (rd_hs_c && last_beat_c) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            a_w       <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == S_IDLE);
            busy      <= (state_d != S_IDLE);
            wr_ready  <= (state_d == S_LOAD);
            rd_valid  <= (state_d == S_STREAM);
            a_w       <= (state_d == S_WRITE);
            done      <= (state_q == S_WRITE) || ((state_q == S_STREAM) && rd_hs_c && last_beat_c);
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q <= cmd_addr;
                        beat_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (wr_hs_c) begin
                        operand_q[32'(beat_q) * Word +: Word] <= wr_data;
                        beat_q <= last_beat_c ? '0 : beat_inc_c;
                    end
                end
                S_READ_WAIT: begin
                    operand_q <= a_data_out;
                    rd_data   <= a_data_out[Word-1:0];
                    beat_q    <= '0;
                end
                S_STREAM: begin
                    if (rd_hs_c) begin
                        beat_q <= last_beat_c ? '0 : beat_inc_c;
                        if (!last_beat_c) begin
                            rd_data <= operand_q[32'(beat_inc_c) * Word +: Word];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_mul_operand_loader.sv
// Directed bench for scalar_mul_operand_loader with a one-cycle synchronous RAM model on port a.
module tb_scalar_mul_operand_loader;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_rd;
    logic [5:0]     cmd_addr;
    logic           wr_valid;
    logic           wr_ready;
    logic [31:0]    wr_data;
    logic           rd_valid;
    logic           rd_ready;
    logic [31:0]    rd_data;
    logic           busy;
    logic           done;
    logic           a_w;
    logic [5:0]     a_adbus;
    logic [255:0]   a_data_in;
    logic [255:0]   a_data_out;

    logic [255:0]   mem [64];

    int compared   = 0;
    int mismatched = 0;

    localparam logic [255:0] D1 = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    localparam logic [255:0] DA = {8{32'hAAAAAAAA}};

    scalar_mul_operand_loader dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rd     (cmd_rd),
        .cmd_addr   (cmd_addr),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .a_w        (a_w),
        .a_adbus    (a_adbus),
        .a_data_in  (a_data_in),
        .a_data_out (a_data_out)
    );

    always #5 clk = ~clk;

    // RAM model: write on a_w, registered read of the presented address.
    always @(posedge clk) begin
        if (a_w) mem[a_adbus] <= a_data_in;
        a_data_out <= mem[a_adbus];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp_v);
        end
    endtask

    // Write an operand; gaps drops wr_valid every third cycle, intrude issues a foreign command mid-load.
    task automatic write_op(input logic [5:0] addr, input logic [255:0] data,
                            input bit gaps, input bit intrude, input int exp_aw);
        int beats = 0;
        int aw_cyc = 0;
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = addr;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c < 60; c++) begin
            if (a_w) begin
                aw_cyc = c;
                break;
            end
            if (intrude && c == 4) begin
                chk("intrude_cmd_ready", cmd_ready, 1'b0);
                chk("intrude_adbus", a_adbus, addr);
            end
            if (intrude && c == 3) begin
                cmd_valid = 1'b1;
                cmd_addr  = addr ^ 6'h3F;
            end
            wr_valid = (beats < 8) && !(gaps && (c % 3 == 0));
            wr_data  = data[beats*32 +: 32];
            if (wr_valid) beats++;
            tick();
        end
        wr_valid = 1'b0; cmd_valid = 1'b0; cmd_addr = addr;
        chk("aw_seen", 256'(aw_cyc != 0), 256'(1));
        if (exp_aw != 0) chk("aw_latency", 256'(aw_cyc), 256'(exp_aw));
        chk("aw_adbus", a_adbus, addr);
        chk("aw_data", a_data_in, data);
        tick();
        chk("wr_done", done, 1'b1);
        chk("wr_done_cmd_ready", cmd_ready, 1'b1);
        chk("wr_aw_single", a_w, 1'b0);
        tick();
        chk("wr_done_single", done, 1'b0);
    endtask

    // Read an operand back; stall applies the rd_ready pattern 1,0,0,1 while beats stream.
    task automatic read_op(input logic [5:0] addr, input logic [255:0] data, input bit stall,
                           input int exp_first, input int exp_done);
        int beats = 0;
        int first = 0;
        int dcyc = 0;
        int p = 0;
        logic [3:0] pat = 4'b1001;
        cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = addr;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c < 80; c++) begin
            if (done) begin
                dcyc = c;
                break;
            end
            if (rd_valid) begin
                if (first == 0) first = c;
                if (beats < 8) chk("rd_beat", rd_data, data[beats*32 +: 32]);
                else chk("rd_extra", rd_valid, 1'b0);
            end
            rd_ready = stall ? pat[p % 4] : 1'b1;
            if (rd_valid) p++;
            if (rd_valid && rd_ready) beats++;
            tick();
        end
        rd_ready = 1'b0;
        chk("rd_done_seen", 256'(dcyc != 0), 256'(1));
        chk("rd_beat_count", 256'(beats), 256'(8));
        chk("rd_adbus", a_adbus, addr);
        if (exp_first != 0) chk("rd_first_latency", 256'(first), 256'(exp_first));
        if (exp_done != 0) chk("rd_done_latency", 256'(dcyc), 256'(exp_done));
        chk("rd_done_rd_valid", rd_valid, 1'b0);
        tick();
        chk("rd_done_single", done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_a_w", a_w, 1'b0);
        chk("rst_a_adbus", a_adbus, 6'h0);
        chk("rst_a_data_in", a_data_in, 256'h0);
        rst = 1'b0;
        tick();

        write_op(6'd5, D1, 1'b0, 1'b0, 9);

        // Beats offered while idle must not touch the operand.
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 32'hBAD0_0000 + 32'(i);
            tick();
            chk("idle_wr_ready", wr_ready, 1'b0);
            chk("idle_operand", a_data_in, D1);
        end
        wr_valid = 1'b0;
        tick();

        read_op(6'd5, D1, 1'b0, 3, 11);
        read_op(6'd5, D1, 1'b1, 0, 0);

        write_op(6'd12, D1, 1'b1, 1'b1, 0);
        read_op(6'd12, D1, 1'b0, 3, 11);

        // Reset after four beats of a write.
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_addr = 6'd9;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 32'hDEAD_0000 + 32'(i);
            tick();
        end
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        chk("mid_rst_a_w", a_w, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_operand", a_data_in, 256'h0);
        tick();
        chk("post_rst_a_w", a_w, 1'b0);
        chk("post_rst_done", done, 1'b0);

        write_op(6'd63, DA, 1'b0, 1'b0, 9);
        read_op(6'd63, DA, 1'b0, 3, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
